// File: rtl/song_address_calc.sv
// song_address_calc: ZBT word address generator for recording and playing songs.
// It advances one word for every three AC97 samples. It keeps a recorded length
// for each song slot, so playback stops at the last word that was recorded.
module song_address_calc #(
    parameter int unsigned BANK_AW   = 19,
    parameter int unsigned SLOT_BITS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    input  logic               start_song,
    input  logic [3:0]         song_choice,
    input  logic               record_mode,
    input  logic               pause_song,
    output logic [BANK_AW-1:0] addr0,
    output logic [BANK_AW-1:0] addr1,
    output logic               song_done
);

    localparam int unsigned OW = BANK_AW - SLOT_BITS;
    localparam int unsigned LW = OW + 1;

    typedef enum logic [1:0] {IDLE, RECORD, PLAY, DONE} state_t;

    state_t          state, state_n;
    logic [3:0]      cur_choice, choice_n;
    logic [1:0]      phase, phase_n;
    logic [OW-1:0]   offset, offset_n;
    logic            done_n;
    logic [LW-1:0]   len_tab [16];
    logic            len_we;
    logic [3:0]      len_idx;
    logic [LW-1:0]   len_wdata;
    logic [LW-1:0]   offset_inc;
    logic            advance;
    logic [BANK_AW-1:0] slot_addr;
    logic [BANK_AW-1:0] addr0_n, addr1_n;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic: start_song takes priority; pause masks ready; DONE and IDLE ignore ready
    always_comb begin
        state_n    = state;
        choice_n   = cur_choice;
        phase_n    = phase;
        offset_n   = offset;
        done_n     = song_done;
        len_we     = 1'b0;
        len_idx    = cur_choice;
        len_wdata  = '0;
        offset_inc = LW'(offset) + LW'(1);
        advance    = ready && !pause_song && (state == RECORD || state == PLAY);

        if (start_song) begin
            choice_n = song_choice;
            phase_n  = 2'd0;
            offset_n = '0;
            done_n   = 1'b0;
            if (record_mode) begin
                state_n   = RECORD;
                len_we    = 1'b1;
                len_idx   = song_choice;
                len_wdata = '0;
            end else if (len_tab[song_choice] == '0) begin
                state_n = DONE;
                done_n  = 1'b1;
            end else begin
                state_n = PLAY;
            end
        end else if (advance) begin
            if (phase != 2'd2) begin
                phase_n = phase + 2'd1;
            end else begin
                phase_n = 2'd0;
                if (state == RECORD) begin
                    len_we    = 1'b1;
                    len_wdata = offset_inc;
                    if (offset == {OW{1'b1}}) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        offset_n = offset_inc[OW-1:0];
                    end
                end else begin
                    if (offset_inc == len_tab[cur_choice]) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        offset_n = offset_inc[OW-1:0];
                    end
                end
            end
        end

        slot_addr = {choice_n[SLOT_BITS-1:0], offset_n};
        addr0_n   = (state_n != IDLE && !choice_n[3]) ? slot_addr : '0;
        addr1_n   = (state_n != IDLE &&  choice_n[3]) ? slot_addr : '0;
    end

    // Datapath registers, length table, and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_choice <= '0;
            phase      <= '0;
            offset     <= '0;
            song_done  <= 1'b0;
            addr0      <= '0;
            addr1      <= '0;
            for (int i = 0; i < 16; i++) len_tab[i] <= '0;
        end else begin
            cur_choice <= choice_n;
            phase      <= phase_n;
            offset     <= offset_n;
            song_done  <= done_n;
            addr0      <= addr0_n;
            addr1      <= addr1_n;
            if (len_we) len_tab[len_idx] <= len_wdata;
        end
    end

endmodule

// File: tb/tb_song_address_calc.sv
// Testbench for song_address_calc. The bench runs a directed vector table and a
// randomized run, and checks both against a sample-count reference model.
// A second, narrow instance checks the full-slot length boundary.
module tb_song_address_calc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ready, start_song, record_mode, pause_song;
    logic [3:0]  song_choice;
    logic [18:0] addr0, addr1;
    logic        song_done;

    song_address_calc dut (
        .clk(clk), .reset(reset), .ready(ready), .start_song(start_song),
        .song_choice(song_choice), .record_mode(record_mode), .pause_song(pause_song),
        .addr0(addr0), .addr1(addr1), .song_done(song_done)
    );

    // Narrow instance: 6-bit offset, so one full slot holds 64 words
    logic       s_reset, s_ready, s_start, s_rec, s_pause;
    logic [3:0] s_choice;
    logic [8:0] s_addr0, s_addr1;
    logic       s_done;

    song_address_calc #(.BANK_AW(9), .SLOT_BITS(3)) dut_s (
        .clk(clk), .reset(s_reset), .ready(s_ready), .start_song(s_start),
        .song_choice(s_choice), .record_mode(s_rec), .pause_song(s_pause),
        .addr0(s_addr0), .addr1(s_addr1), .song_done(s_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the song position is a count of samples taken; word = n/3.
    // The model state is 0 idle, 1 record, 2 play, 3 done.
    int m_state = 0;
    int m_choice = 0;
    int m_n = 0;
    int m_len [16];
    localparam int WORDS = 65536;

    task automatic model_step();
        if (reset) begin
            m_state = 0; m_choice = 0; m_n = 0;
            for (int i = 0; i < 16; i++) m_len[i] = 0;
        end else if (start_song) begin
            m_choice = int'(song_choice);
            m_n = 0;
            if (record_mode) begin
                m_state = 1;
                m_len[m_choice] = 0;
            end else begin
                m_state = (m_len[m_choice] == 0) ? 3 : 2;
            end
        end else if (ready && !pause_song && (m_state == 1 || m_state == 2)) begin
            m_n++;
            if (m_n % 3 == 0) begin
                if (m_state == 1) begin
                    m_len[m_choice] = m_n / 3;
                    if (m_n / 3 == WORDS) m_state = 3;
                end else if (m_n / 3 == m_len[m_choice]) begin
                    m_state = 3;
                end
            end
        end
    endtask

    task automatic model_check();
        int w, off, a;
        w   = m_n / 3;
        off = (m_state == 3 && w > 0) ? w - 1 : w;
        a   = ((m_choice & 7) << 16) | off;
        check("model_addr0", 32'(addr0), (m_state != 0 && m_choice < 8)  ? a : 0);
        check("model_addr1", 32'(addr1), (m_state != 0 && m_choice >= 8) ? a : 0);
        check("model_done",  32'(song_done), (m_state == 3) ? 1 : 0);
    endtask

    // One clock on the main DUT: drive inputs, clock, step the model, compare
    task automatic cyc(input bit r, input bit st, input logic [3:0] ch,
                       input bit rec, input bit pa, input bit rd);
        reset = r; start_song = st; song_choice = ch;
        record_mode = rec; pause_song = pa; ready = rd;
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    task automatic s_cyc(input bit r, input bit st, input logic [3:0] ch,
                         input bit rec, input bit rd);
        s_reset = r; s_start = st; s_choice = ch; s_rec = rec; s_pause = 1'b0; s_ready = rd;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         r, st;
        logic [3:0] ch;
        bit         rec, pa, rd;
        int         rep;
        int         e0, e1;
        bit         ed;
    } vec_t;

    vec_t vt [$];

    function automatic vec_t mk(bit r, bit st, logic [3:0] ch, bit rec, bit pa, bit rd,
                                int rep, int e0, int e1, bit ed);
        vec_t v;
        v.r = r; v.st = st; v.ch = ch; v.rec = rec; v.pa = pa; v.rd = rd;
        v.rep = rep; v.e0 = e0; v.e1 = e1; v.ed = ed;
        return v;
    endfunction

    initial begin
        reset = 1'b1; ready = 1'b0; start_song = 1'b0; song_choice = '0;
        record_mode = 1'b0; pause_song = 1'b0;
        s_reset = 1'b1; s_ready = 1'b0; s_start = 1'b0; s_choice = '0; s_rec = 1'b0; s_pause = 1'b0;
        for (int i = 0; i < 16; i++) m_len[i] = 0;

        //            r st ch     rec pa rd rep  addr0     addr1     done
        vt.push_back(mk(1, 0, 4'd0,  0, 0, 0, 1, 0,        0,        0));
        vt.push_back(mk(0, 0, 4'd0,  0, 0, 1, 3, 0,        0,        0));
        vt.push_back(mk(0, 1, 4'd10, 1, 0, 0, 1, 0,        'h20000,  0));
        vt.push_back(mk(0, 0, 4'd0,  0, 0, 1, 9, 0,        'h20003,  0));
        vt.push_back(mk(0, 0, 4'd0,  0, 1, 1, 5, 0,        'h20003,  0));
        vt.push_back(mk(0, 0, 4'd0,  0, 0, 1, 2, 0,        'h20003,  0));
        vt.push_back(mk(0, 1, 4'd10, 1, 0, 1, 1, 0,        'h20000,  0));
        vt.push_back(mk(0, 0, 4'd0,  0, 0, 1, 2, 0,        'h20000,  0));
        vt.push_back(mk(0, 0, 4'd0,  0, 0, 1, 1, 0,        'h20001,  0));
        vt.push_back(mk(0, 0, 4'd0,  0, 0, 1, 6, 0,        'h20003,  0));
        vt.push_back(mk(0, 1, 4'd10, 0, 0, 0, 1, 0,        'h20000,  0));
        vt.push_back(mk(0, 0, 4'd0,  0, 0, 1, 8, 0,        'h20002,  0));
        vt.push_back(mk(0, 0, 4'd0,  0, 0, 1, 1, 0,        'h20002,  1));
        vt.push_back(mk(0, 0, 4'd0,  0, 0, 1, 3, 0,        'h20002,  1));
        vt.push_back(mk(0, 0, 4'd0,  0, 1, 0, 1, 0,        'h20002,  1));
        vt.push_back(mk(0, 1, 4'd3,  0, 0, 0, 1, 'h30000,  0,        1));
        vt.push_back(mk(0, 0, 4'd12, 1, 0, 1, 3, 'h30000,  0,        1));
        vt.push_back(mk(0, 1, 4'd10, 0, 0, 0, 1, 0,        'h20000,  0));
        vt.push_back(mk(0, 0, 4'd0,  0, 0, 1, 3, 0,        'h20001,  0));
        vt.push_back(mk(1, 0, 4'd0,  0, 0, 0, 1, 0,        0,        0));
        vt.push_back(mk(0, 1, 4'd10, 0, 0, 0, 1, 0,        'h20000,  1));
        vt.push_back(mk(0, 1, 4'd5,  1, 0, 0, 1, 'h50000,  0,        0));
        vt.push_back(mk(0, 0, 4'd0,  0, 0, 1, 3, 'h50001,  0,        0));
        vt.push_back(mk(0, 0, 4'd0,  0, 1, 0, 1, 'h50001,  0,        0));

        // Directed table: apply each row rep times, then compare against the table expectation
        foreach (vt[k]) begin
            for (int j = 0; j < vt[k].rep; j++)
                cyc(vt[k].r, vt[k].st, vt[k].ch, vt[k].rec, vt[k].pa, vt[k].rd);
            check($sformatf("vec%0d_addr0", k), 32'(addr0), vt[k].e0);
            check($sformatf("vec%0d_addr1", k), 32'(addr1), vt[k].e1);
            check($sformatf("vec%0d_done", k),  32'(song_done), 32'(vt[k].ed));
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 399) == 0, $urandom_range(0, 59) == 0, 4'($urandom),
                1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
        end
        cyc(0, 0, 4'd0, 0, 0, 0);

        // Full-slot boundary on the narrow instance: slot 6 of bank 0 is at base 6*64 = 384
        s_cyc(1, 0, 4'd0, 0, 0);
        check("s_reset_addr0", 32'(s_addr0), 0);
        s_cyc(0, 1, 4'd6, 1, 0);
        check("s_rec_start", 32'(s_addr0), 384);
        for (int i = 0; i < 189; i++) s_cyc(0, 0, 4'd0, 0, 1);
        check("s_rec_last_addr", 32'(s_addr0), 447);
        check("s_rec_last_done", 32'(s_done), 0);
        for (int i = 0; i < 3; i++) s_cyc(0, 0, 4'd0, 0, 1);
        check("s_rec_full_addr", 32'(s_addr0), 447);
        check("s_rec_full_done", 32'(s_done), 1);
        check("s_rec_addr1", 32'(s_addr1), 0);
        s_cyc(0, 1, 4'd6, 0, 0);
        check("s_play_start_addr", 32'(s_addr0), 384);
        check("s_play_start_done", 32'(s_done), 0);
        for (int i = 0; i < 189; i++) s_cyc(0, 0, 4'd0, 0, 1);
        check("s_play_last_addr", 32'(s_addr0), 447);
        check("s_play_last_done", 32'(s_done), 0);
        for (int i = 0; i < 3; i++) s_cyc(0, 0, 4'd0, 0, 1);
        check("s_play_end_addr", 32'(s_addr0), 447);
        check("s_play_end_done", 32'(s_done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
